// File: rtl/dvga_timing_gen.sv
// dvga_timing_gen: free-running video timing (position, syncs, blank, frame/line events)
module dvga_timing_gen #(
    parameter int XCNTW     = 11,
    parameter int YCNTW     = 10,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             pixce_i,
    output logic [XCNTW-1:0] xpos_o,
    output logic [YCNTW-1:0] ypos_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             blank_o,
    output logic             sof_o,
    output logic             eol_o,
    output logic             vbl_o,
    output logic [7:0]       frame_cnt_o
);
    localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [XCNTW-1:0] H_LAST  = XCNTW'(HTOTAL - 1);
    localparam logic [XCNTW-1:0] H_ACT   = XCNTW'(H_ACTIVE);
    localparam logic [XCNTW-1:0] H_EOL   = XCNTW'(H_ACTIVE - 1);
    localparam logic [XCNTW-1:0] HS_BEG  = XCNTW'(H_ACTIVE + H_FP);
    localparam logic [XCNTW-1:0] HS_END  = XCNTW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YCNTW-1:0] V_LAST  = YCNTW'(VTOTAL - 1);
    localparam logic [YCNTW-1:0] V_ACT   = YCNTW'(V_ACTIVE);
    localparam logic [YCNTW-1:0] VS_BEG  = YCNTW'(V_ACTIVE + V_FP);
    localparam logic [YCNTW-1:0] VS_END  = YCNTW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic HS_ON = 1'(HSYNC_POL);
    localparam logic VS_ON = 1'(VSYNC_POL);

    logic [XCNTW-1:0] hcnt_q, hcnt_d, xpos_q, xpos_d;
    logic [YCNTW-1:0] vcnt_q, vcnt_d, ypos_q, ypos_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
    logic             sof_q, sof_d, eol_q, eol_d, vbl_q, vbl_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             adv, h_wrap, v_wrap, hs_act, vs_act, in_blank;

    always_comb begin
        adv      = en_i && pixce_i;
        h_wrap   = hcnt_q == H_LAST;
        v_wrap   = vcnt_q == V_LAST;
        hs_act   = hcnt_q >= HS_BEG && hcnt_q < HS_END;
        vs_act   = vcnt_q >= VS_BEG && vcnt_q < VS_END;
        in_blank = hcnt_q >= H_ACT || vcnt_q >= V_ACT;
        hcnt_d   = !en_i ? '0 : !pixce_i ? hcnt_q : h_wrap ? '0 : hcnt_q + 1'b1;
        vcnt_d   = !en_i ? '0 : !(pixce_i && h_wrap) ? vcnt_q : v_wrap ? '0 : vcnt_q + 1'b1;
        // Disabled generator parks its outputs at their reset values
        xpos_d   = !en_i ? '0 : adv ? hcnt_q : xpos_q;
        ypos_d   = !en_i ? '0 : adv ? vcnt_q : ypos_q;
        hsync_d  = !en_i ? !HS_ON : adv ? (hs_act ? HS_ON : !HS_ON) : hsync_q;
        vsync_d  = !en_i ? !VS_ON : adv ? (vs_act ? VS_ON : !VS_ON) : vsync_q;
        blank_d  = !en_i ? 1'b1 : adv ? in_blank : blank_q;
        sof_d    = adv && hcnt_q == '0 && vcnt_q == '0;
        eol_d    = adv && hcnt_q == H_EOL && vcnt_q < V_ACT;
        vbl_d    = adv && hcnt_q == '0 && vcnt_q == V_ACT;
        frame_cnt_d = frame_cnt_q + {7'd0, sof_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            xpos_q      <= '0;
            ypos_q      <= '0;
            hsync_q     <= !HS_ON;
            vsync_q     <= !VS_ON;
            blank_q     <= 1'b1;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            vbl_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            blank_q     <= blank_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            vbl_q       <= vbl_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign xpos_o      = xpos_q;
    assign ypos_o      = ypos_q;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign blank_o     = blank_q;
    assign sof_o       = sof_q;
    assign eol_o       = eol_q;
    assign vbl_o       = vbl_q;
    assign frame_cnt_o = frame_cnt_q;
endmodule

// File: tb/tb_dvga_timing_gen.sv
// tb_dvga_timing_gen: directed vectors and frame sequences on a 16x8 timing config
module tb_dvga_timing_gen;
    logic        clk = 1'b0;
    logic        rst, en_i, pixce_i;
    logic [10:0] xpos_o;
    logic [9:0]  ypos_o;
    logic        hsync_o, vsync_o, blank_o, sof_o, eol_o, vbl_o;
    logic [7:0]  frame_cnt_o;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic en, pix;
        int   x, y;
        logic hs, vs, bl, sof, eol, vbl;
        int   fc;
    } vec_t;

    dvga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .pixce_i(pixce_i),
        .xpos_o(xpos_o), .ypos_o(ypos_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .blank_o(blank_o), .sof_o(sof_o), .eol_o(eol_o), .vbl_o(vbl_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int x, input int y, input logic hs, input logic vs,
                                       input logic bl, input logic sof, input logic eol,
                                       input logic vbl, input int fc);
        return {29'd0, x[10:0], y[9:0], hs, vs, bl, sof, eol, vbl, fc[7:0]};
    endfunction

    function automatic logic [63:0] obs();
        return pk(int'(xpos_o), int'(ypos_o), hsync_o, vsync_o, blank_o, sof_o, eol_o, vbl_o,
                  int'(frame_cnt_o));
    endfunction

    vec_t vq[$];

    initial begin
        int bx, by, efc, nsof, nvbl, fc_saved, guard;
        logic esof;
        // hand-computed vectors from reset release, pixce toggling early on
        vq.push_back('{1,1, 0,0, 1,1,0, 1,0,0, 1});
        vq.push_back('{1,1, 1,0, 1,1,0, 0,0,0, 1});
        vq.push_back('{1,0, 1,0, 1,1,0, 0,0,0, 1});
        vq.push_back('{1,1, 2,0, 1,1,0, 0,0,0, 1});
        vq.push_back('{1,0, 2,0, 1,1,0, 0,0,0, 1});
        vq.push_back('{1,1, 3,0, 1,1,0, 0,0,0, 1});
        vq.push_back('{1,1, 4,0, 1,1,0, 0,0,0, 1});
        vq.push_back('{1,1, 5,0, 1,1,0, 0,0,0, 1});
        vq.push_back('{1,1, 6,0, 1,1,0, 0,0,0, 1});
        vq.push_back('{1,1, 7,0, 1,1,0, 0,1,0, 1});
        vq.push_back('{1,0, 7,0, 1,1,0, 0,0,0, 1});
        vq.push_back('{1,1, 8,0, 1,1,1, 0,0,0, 1});
        vq.push_back('{1,1, 9,0, 1,1,1, 0,0,0, 1});
        vq.push_back('{1,1,10,0, 0,1,1, 0,0,0, 1});
        vq.push_back('{1,1,11,0, 0,1,1, 0,0,0, 1});
        vq.push_back('{1,1,12,0, 0,1,1, 0,0,0, 1});
        vq.push_back('{1,1,13,0, 1,1,1, 0,0,0, 1});
        vq.push_back('{1,1,14,0, 1,1,1, 0,0,0, 1});
        vq.push_back('{1,1,15,0, 1,1,1, 0,0,0, 1});
        vq.push_back('{1,1, 0,1, 1,1,0, 0,0,0, 1});

        rst = 1'b1; en_i = 1'b0; pixce_i = 1'b1;
        tick; tick;
        check("reset", obs(), pk(0,0,1,1,1,0,0,0,0));
        en_i = 1'b1;
        tick;
        check("reset_dominates_en", obs(), pk(0,0,1,1,1,0,0,0,0));
        rst = 1'b0;
        foreach (vq[i]) begin
            en_i = vq[i].en; pixce_i = vq[i].pix;
            tick;
            check($sformatf("vec%0d", i), obs(),
                  pk(vq[i].x, vq[i].y, vq[i].hs, vq[i].vs, vq[i].bl,
                     vq[i].sof, vq[i].eol, vq[i].vbl, vq[i].fc));
        end

        // three full frames against a position model built from the small-config timing
        pixce_i = 1'b1; bx = 1; by = 1; efc = 1; nsof = 0; nvbl = 0;
        for (int e = 0; e < 384; e++) begin
            tick;
            esof = (bx == 0 && by == 0);
            efc = (efc + int'(esof)) & 255;
            check($sformatf("sweep x%0d y%0d", bx, by), obs(),
                  pk(bx, by, !(bx >= 10 && bx <= 12), !(by >= 5 && by <= 6),
                     bx >= 8 || by >= 4, esof, bx == 7 && by < 4, bx == 0 && by == 4, efc));
            nsof += int'(sof_o);
            nvbl += int'(vbl_o);
            bx = (bx + 1) % 16;
            if (bx == 0) by = (by + 1) % 8;
        end
        check("sof_per_3_frames", nsof, 3);
        check("vbl_per_3_frames", nvbl, 3);

        // frame counter wraps 255 -> 0
        rst = 1'b1; tick; rst = 1'b0;
        nsof = 0;
        for (int e = 0; e < 33100 && nsof < 257; e++) begin
            tick;
            if (sof_o) begin
                nsof++;
                check($sformatf("frame_cnt sof%0d", nsof), frame_cnt_o, nsof & 255);
            end
        end
        check("frame_wrap_reached", nsof, 257);

        // disable at (5,2), then re-enable
        guard = 0;
        while (!(xpos_o == 5 && ypos_o == 2) && guard < 300) begin
            tick; guard++;
        end
        check("reach_x5_y2", guard < 300, 1);
        fc_saved = int'(frame_cnt_o);
        en_i = 1'b0;
        tick;
        check("en_off", obs(), pk(0,0,1,1,1,0,0,0,fc_saved));
        pixce_i = 1'b0;
        tick;
        check("en_off_pix0", obs(), pk(0,0,1,1,1,0,0,0,fc_saved));
        en_i = 1'b1;
        tick;
        check("en_on_pix0", obs(), pk(0,0,1,1,1,0,0,0,fc_saved));
        pixce_i = 1'b1;
        tick;
        check("restart_sof", obs(), pk(0,0,1,1,0,1,0,0,(fc_saved + 1) & 255));
        tick;
        check("restart_x1", obs(), pk(1,0,1,1,0,0,0,0,(fc_saved + 1) & 255));

        // reset mid-frame
        for (int e = 0; e < 40; e++) tick;
        rst = 1'b1;
        tick;
        check("rst_mid_frame", obs(), pk(0,0,1,1,1,0,0,0,0));
        rst = 1'b0;
        tick;
        check("after_rst_sof", obs(), pk(0,0,1,1,0,1,0,0,1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
